// File: rtl/approx_adder_if.sv
// Stream interface for the approximate adder pipeline.
//
// Groups the operand (input) handshake and the result (output) handshake.
//   master : stimulus side; drives operands and out_ready, observes results.
//   slave  : adder side; accepts operands, drives in_ready and results.
//
// Signals:
//   in_valid / in_ready  operand beat handshake
//   a, b                 operands, WIDTH bits
//   trunc                number of approximated LSBs for the beat
//   out_valid / out_ready result beat handshake
//   sum_apx, sum_exact, err  result payload, WIDTH+1 bits each
interface approx_adder_if #(
    parameter int WIDTH = 16
);
    localparam int TW = $clog2(WIDTH + 1) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TW-1:0]    trunc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum_apx;
    logic [WIDTH:0]   sum_exact;
    logic [WIDTH:0]   err;

    modport master (
        output in_valid, a, b, trunc, out_ready,
        input  in_ready, out_valid, sum_apx, sum_exact, err
    );

    modport slave (
        input  in_valid, a, b, trunc, out_ready,
        output in_ready, out_valid, sum_apx, sum_exact, err
    );
endinterface

// File: rtl/approx_adder_pipe.sv
// Pipelined truncation-approximate adder with a built-in error monitor.
//
// The low k = min(trunc, WIDTH) bits of both operands are ignored, so no
// carry enters bit k and the low k result bits are zero. The exact sum is
// computed alongside, and the difference is carried down the pipeline with
// the result so the statistics see exactly the beat being delivered.
//
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   bus          approx_adder_if slave: operand and result handshakes
//   stat_clr     synchronous clear of all statistics (wins over an update)
//   n_samples    result beats transferred (saturating)
//   n_errors     transferred beats with err != 0 (saturating)
//   err_max      largest err transferred
//   err_sum      sum of err over transferred beats (saturating)
module approx_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    approx_adder_if.slave          bus,
    input  logic                   stat_clr,
    output logic [CNT_W-1:0]       n_samples,
    output logic [CNT_W-1:0]       n_errors,
    output logic [WIDTH:0]         err_max,
    output logic [CNT_W+WIDTH-1:0] err_sum
);
    localparam int TW   = $clog2(WIDTH + 1) + 1;
    localparam int SW   = WIDTH + 1;
    localparam int CW1  = CNT_W + 1;
    localparam int ESW1 = CNT_W + WIDTH + 1;

    logic [TW-1:0]    k;
    logic [WIDTH-1:0] keep_mask;
    logic [SW-1:0]    apx_in;
    logic [SW-1:0]    exact_in;
    logic [SW-1:0]    err_in;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [SW-1:0]     apx_q   [STAGES];
    logic [SW-1:0]     exact_q [STAGES];
    logic [SW-1:0]     err_q   [STAGES];

    logic              out_xfer;
    logic [CW1-1:0]    samples_inc;
    logic [CW1-1:0]    errors_inc;
    logic [ESW1-1:0]   sum_inc;

    // Masking both operands' low k bits before a full-width add is the same
    // as ((a>>k)+(b>>k))<<k, and the mask is all zeros when k == WIDTH.
    always_comb begin
        k         = (bus.trunc > TW'(WIDTH)) ? TW'(WIDTH) : bus.trunc;
        keep_mask = ~(WIDTH'((SW'(1) << k) - SW'(1)));
        exact_in  = {1'b0, bus.a} + {1'b0, bus.b};
        apx_in    = {1'b0, bus.a & keep_mask} + {1'b0, bus.b & keep_mask};
        err_in    = exact_in - apx_in;
    end

    // A stage may take new data when some stage at or after it is empty, or
    // when the output is being consumed. Written in this closed form so no
    // advance bit depends on another.
    always_comb begin
        adv = '0;
        for (int i = 0; i < STAGES; i++) begin
            adv[i] = bus.out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!vld[j]) begin
                    adv[i] = 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = adv[0];

    // Stage 0 captures a, b and trunc's effect on an input transfer; later
    // stages shift forward when allowed. Payload only loads with a valid beat
    // so a stalled or drained output keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                apx_q[i]   <= '0;
                exact_q[i] <= '0;
                err_q[i]   <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    apx_q[0]   <= apx_in;
                    exact_q[0] <= exact_in;
                    err_q[0]   <= err_in;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        apx_q[i]   <= apx_q[i-1];
                        exact_q[i] <= exact_q[i-1];
                        err_q[i]   <= err_q[i-1];
                    end
                end
            end
        end
    end

    assign bus.out_valid = vld[STAGES-1];
    assign bus.sum_apx   = apx_q[STAGES-1];
    assign bus.sum_exact = exact_q[STAGES-1];
    assign bus.err       = err_q[STAGES-1];

    assign out_xfer = vld[STAGES-1] & bus.out_ready;

    // One extra bit on each increment exposes overflow so counters can stick
    // at all-ones instead of wrapping.
    always_comb begin
        samples_inc = {1'b0, n_samples} + CW1'(1);
        errors_inc  = {1'b0, n_errors} + CW1'(1);
        sum_inc     = {1'b0, err_sum} + ESW1'(err_q[STAGES-1]);
    end

    // Statistics follow delivered beats only; a clear in the same cycle as a
    // transfer discards that beat's contribution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_samples <= '0;
            n_errors  <= '0;
            err_max   <= '0;
            err_sum   <= '0;
        end else if (stat_clr) begin
            n_samples <= '0;
            n_errors  <= '0;
            err_max   <= '0;
            err_sum   <= '0;
        end else if (out_xfer) begin
            n_samples <= samples_inc[CNT_W] ? '1 : samples_inc[CNT_W-1:0];
            if (err_q[STAGES-1] != '0) begin
                n_errors <= errors_inc[CNT_W] ? '1 : errors_inc[CNT_W-1:0];
            end
            if (err_q[STAGES-1] > err_max) begin
                err_max <= err_q[STAGES-1];
            end
            err_sum <= sum_inc[ESW1-1] ? '1 : sum_inc[ESW1-2:0];
        end
    end
endmodule

// File: doc/approx_adder_pipe.md
Name: approx_adder_pipe

Overview:
Parametrised, pipelined truncation-approximate adder: the next generation of the fixed 16-bit/17-output approximate adder netlists. Operand width, pipeline depth and the number of truncated LSBs are all configurable, and the truncation is selectable per transaction. A built-in error monitor computes the exact sum in parallel and accumulates error statistics in hardware. Sits between the stimulus source and the scoreboard in the error-evaluation harness, replacing offline error computation.

Parameters:
WIDTH, 16, operand width in bits; sum width is WIDTH+1.
STAGES, 2, pipeline depth (legal 1..4); also the fixed transfer latency.
CNT_W, 32, width of every statistics counter.

Ports:
clk  in  1  clock, all state rising-edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
trunc  in  $clog2(WIDTH+1)+1  number of LSBs approximated for this beat.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts result.
sum_apx  out  WIDTH+1  approximate sum.
sum_exact  out  WIDTH+1  exact a+b.
err  out  WIDTH+1  sum_exact - sum_apx, always >= 0.
stat_clr  in  1  synchronous clear of all statistics.
n_samples  out  CNT_W  result beats transferred.
n_errors  out  CNT_W  transferred beats with err != 0.
err_max  out  WIDTH+1  largest err transferred.
err_sum  out  CNT_W+WIDTH  sum of err over transferred beats.

Behaviour:
- Arithmetic: k = min(trunc, WIDTH). sum_apx = ((a>>k)+(b>>k))<<k. The carry into bit k is 0, and bits k-1..0 of sum_apx are 0. sum_exact = a+b, zero-extended to WIDTH+1. err = sum_exact - sum_apx, which is always in [0, 2^(k+1)-2]. k=0 gives err=0. k=WIDTH gives sum_apx=0.
- trunc values above WIDTH clamp to WIDTH. No error is flagged.
- trunc, a and b are captured together on an input transfer (in_valid & in_ready).
- Pipeline: STAGES registered stages. Each stage holds a valid bit plus payload.
  - An output transfer is out_valid & out_ready.
  - Latency: a beat accepted on edge N is presented with out_valid=1 after edge N+STAGES-1, provided out_ready stays high.
  - Throughput is 1 beat/cycle while out_ready=1.
- Backpressure: stage i advances when it is empty or stage i+1 advances. in_ready = (stage 1 empty) OR (stage 1 advances); it may depend combinationally on out_ready.
  - No beat is dropped or duplicated.
  - While out_valid=1 and out_ready=0, the output payload holds stable.
- Statistics update on the edge of each output transfer:
  - n_samples += 1.
  - n_errors += (err != 0).
  - err_max = max(err_max, err).
  - err_sum += err.
  - All counters saturate at all-ones and never wrap.
- stat_clr=1 zeroes all statistics on the next edge. If an output transfer occurs in the same cycle, clear wins and that beat is not counted. The beat is still delivered.
- stat_clr does not affect the pipeline.
- Reset (asynchronous, any time, including mid-stream):
  - All stage valids clear, so out_valid=0.
  - sum_apx, sum_exact, err = 0.
  - All statistics = 0.
  - in_ready = 1 after reset deasserts.
  - In-flight beats are discarded.
- Outputs are registered except in_ready.

Test Plan:
- WIDTH=16, k=4, a=0x00FF, b=0x0001 -> sum_exact=0x00100, sum_apx=0x000F0, err=0x10; n_errors=1, err_max=0x10.
- k=0, a=0xFFFF, b=0x0001 -> sum_apx=sum_exact=0x10000, err=0; n_samples increments, n_errors unchanged.
- k=16, then trunc=20 (clamped), a=0x8000, b=0x8000 -> sum_apx=0, err=0x10000 for both beats; err_max=0x10000.
- Stream 10 beats with out_ready toggling 1,0,0,1,... -> results in order, none lost or duplicated, payload stable while stalled, first result visible STAGES cycles after accept; n_samples=10.
- Assert stat_clr on the same edge as an output transfer with err=5 -> all statistics read 0 next cycle, beat still delivered. Force CNT_W=4 and run 20 beats -> n_samples saturates at 15.
- Assert rst with 2 beats in flight -> out_valid drops immediately, statistics 0. After release, a fresh beat returns correct values with latency STAGES.
